// File: rtl/tile_scheduler_if.sv
// Command and tile-processor handshake bundle for tile_scheduler.
// The scheduler connects through the slave modport; its driver uses master.
interface tile_scheduler_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_rows;
  logic [2:0] cmd_cols;
  logic       tp_start;
  logic [2:0] tp_tile_i;
  logic [2:0] tp_tile_j;
  logic [2:0] tp_op_code;
  logic       tp_done;
  logic       busy;
  logic       sched_done;
  logic       err_timeout;
  logic       err_op;
  logic [6:0] tiles_done;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rows, cmd_cols, tp_done,
    output cmd_ready, tp_start, tp_tile_i, tp_tile_j, tp_op_code,
           busy, sched_done, err_timeout, err_op, tiles_done
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rows, cmd_cols, tp_done,
    input  cmd_ready, tp_start, tp_tile_i, tp_tile_j, tp_op_code,
           busy, sched_done, err_timeout, err_op, tiles_done
  );
endinterface

// File: rtl/tile_scheduler.sv
// Walks a rows x cols tile grid in row-major order, starting one tile at a time
// on a tile processor and bounding each tile's completion wait with a timeout.
module tile_scheduler #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic            clk,
  input  logic            rst,
  tile_scheduler_if.slave bus
);

  localparam int            CW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    OP_MAX    = 3'd4;
  localparam logic [6:0]    TILES_MAX = 7'd64;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]    r_state;
  logic [2:0]    r_op;
  logic [2:0]    r_rows;
  logic [2:0]    r_cols;
  logic [2:0]    r_tile_i;
  logic [2:0]    r_tile_j;
  logic [6:0]    r_tiles_done;
  logic [CW-1:0] r_tmo_cnt;
  logic          r_tp_done_q;
  logic          r_err_timeout;
  logic          r_err_op;
  logic          r_sched_done;

  logic w_accept;
  logic w_rise;
  logic w_last_tile;
  logic w_expired;

  assign w_accept    = (r_state == S_IDLE) && bus.cmd_valid;
  assign w_rise      = bus.tp_done && !r_tp_done_q;
  assign w_last_tile = (r_tile_i == r_rows) && (r_tile_j == r_cols);
  assign w_expired   = (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_op          <= 3'd0;
      r_rows        <= 3'd0;
      r_cols        <= 3'd0;
      r_tile_i      <= 3'd0;
      r_tile_j      <= 3'd0;
      r_tiles_done  <= 7'd0;
      r_tmo_cnt     <= '0;
      r_tp_done_q   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_op      <= 1'b0;
      r_sched_done  <= 1'b0;
    end else begin
      r_tp_done_q <= bus.tp_done;
      // Done pulse lands the cycle after FINISH, once the FSM is back in IDLE.
      r_sched_done <= (r_state == S_FINISH);

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op          <= bus.cmd_op;
            r_rows        <= bus.cmd_rows;
            r_cols        <= bus.cmd_cols;
            r_tile_i      <= 3'd0;
            r_tile_j      <= 3'd0;
            r_tiles_done  <= 7'd0;
            r_err_timeout <= 1'b0;
            if (bus.cmd_op > OP_MAX) begin
              r_err_op <= 1'b1;
              r_state  <= S_FINISH;
            end else begin
              r_err_op <= 1'b0;
              r_state  <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          r_tmo_cnt <= '0;
          r_state   <= S_WAIT;
        end

        S_WAIT: begin
          // A completion edge wins over an expiring timeout in the same cycle.
          if (w_rise) begin
            if (r_tiles_done != TILES_MAX) begin
              r_tiles_done <= r_tiles_done + 7'd1;
            end
            if (w_last_tile) begin
              r_state <= S_FINISH;
            end else begin
              if (r_tile_j == r_cols) begin
                r_tile_j <= 3'd0;
                r_tile_i <= r_tile_i + 3'd1;
              end else begin
                r_tile_j <= r_tile_j + 3'd1;
              end
              r_state <= S_ISSUE;
            end
          end else if (w_expired) begin
            r_err_timeout <= 1'b1;
            r_state       <= S_FINISH;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + CW'(1);
          end
        end

        S_FINISH: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.tp_start    = (r_state == S_ISSUE);
  assign bus.tp_tile_i   = r_tile_i;
  assign bus.tp_tile_j   = r_tile_j;
  assign bus.tp_op_code  = r_op;
  assign bus.sched_done  = r_sched_done;
  assign bus.err_timeout = r_err_timeout;
  assign bus.err_op      = r_err_op;
  assign bus.tiles_done  = r_tiles_done;

endmodule

// File: tb/tb_tile_scheduler.sv
// Randomized bench for tile_scheduler: a tile-processor responder plus a
// cycle-count reference model of the expected tile starts and command end.
module tb_tile_scheduler;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tile_scheduler_if bus();

  tile_scheduler #(.TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int dly [64];   // per-tile completion delay, in WAIT cycles after tp_start

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val($sformatf("%s.cmd_ready", tag), int'(bus.cmd_ready), 1);
    check_val($sformatf("%s.busy", tag), int'(bus.busy), 0);
    check_val($sformatf("%s.tp_start", tag), int'(bus.tp_start), 0);
    check_val($sformatf("%s.tile_i", tag), int'(bus.tp_tile_i), 0);
    check_val($sformatf("%s.tile_j", tag), int'(bus.tp_tile_j), 0);
    check_val($sformatf("%s.op_code", tag), int'(bus.tp_op_code), 0);
    check_val($sformatf("%s.sched_done", tag), int'(bus.sched_done), 0);
    check_val($sformatf("%s.err_timeout", tag), int'(bus.err_timeout), 0);
    check_val($sformatf("%s.err_op", tag), int'(bus.err_op), 0);
    check_val($sformatf("%s.tiles_done", tag), int'(bus.tiles_done), 0);
  endtask

  // Called at a falling edge; the command is offered for the next rising edge.
  // hold=1: tp_done rises once (tile 0) and then stays high.
  task automatic run_cmd(input int op, input int rows, input int cols,
                         input bit hold, input string name);
    int exp_n, exp_tiles, exp_sched, cur, w, d;
    bit exp_tmo, exp_eop;
    int exp_cyc [64];
    int exp_i   [64];
    int exp_j   [64];
    int obs_n, sched_cnt, sched_cyc, busy_bad, op_bad, rise_at;
    int obs_cyc [64];
    int obs_i   [64];
    int obs_j   [64];

    // Reference: acceptance cycle is 0; each tile costs one issue cycle plus
    // its wait (delay, or T on timeout); then a finish cycle, then sched_done.
    exp_n = 0; exp_tiles = 0; exp_tmo = 1'b0; exp_eop = (op > 4); cur = 1;
    if (!exp_eop) begin
      for (int i = 0; i <= rows && !exp_tmo; i++) begin
        for (int j = 0; j <= cols && !exp_tmo; j++) begin
          exp_cyc[exp_n] = cur; exp_i[exp_n] = i; exp_j[exp_n] = j;
          d = (hold && exp_n > 0) ? T + 1 : dly[exp_n];
          if (d <= T) begin
            w = d; exp_tiles++;
          end else begin
            w = T; exp_tmo = 1'b1;
          end
          exp_n++;
          cur += 1 + w;
        end
      end
    end
    exp_sched = cur + 1;

    check_val($sformatf("%s.ready", name), int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'(op);
    bus.cmd_rows  = 3'(rows);
    bus.cmd_cols  = 3'(cols);
    bus.tp_done   = 1'b0;
    obs_n = 0; sched_cnt = 0; sched_cyc = -1; busy_bad = 0; op_bad = 0;
    rise_at = 1 << 30;

    for (int n = 1; n <= exp_sched + 3; n++) begin
      @(negedge clk);
      if (bus.tp_start) begin
        if (obs_n < 64) begin
          obs_cyc[obs_n] = n;
          obs_i[obs_n]   = int'(bus.tp_tile_i);
          obs_j[obs_n]   = int'(bus.tp_tile_j);
        end
        if (!hold || obs_n == 0) rise_at = n + dly[(obs_n < 64) ? obs_n : 63];
        if (bus.tp_op_code != 3'(op)) op_bad++;
        obs_n++;
      end
      if (bus.sched_done) begin
        sched_cnt++;
        if (sched_cyc < 0) sched_cyc = n;
      end
      if (bus.busy != (n < exp_sched)) busy_bad++;
      if (bus.cmd_ready == bus.busy) busy_bad++;
      bus.tp_done = hold ? (n >= rise_at) : (n == rise_at);
      // Random traffic while busy must be ignored.
      if (n < exp_sched) begin
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_op    = 3'($urandom);
        bus.cmd_rows  = 3'($urandom);
        bus.cmd_cols  = 3'($urandom);
      end else begin
        bus.cmd_valid = 1'b0;
      end
    end

    check_val($sformatf("%s.starts", name), obs_n, exp_n);
    for (int k = 0; k < exp_n && k < obs_n && k < 64; k++) begin
      check_val($sformatf("%s.start%0d_cyc", name, k), obs_cyc[k], exp_cyc[k]);
      check_val($sformatf("%s.start%0d_i", name, k), obs_i[k], exp_i[k]);
      check_val($sformatf("%s.start%0d_j", name, k), obs_j[k], exp_j[k]);
    end
    check_val($sformatf("%s.sched_cnt", name), sched_cnt, 1);
    check_val($sformatf("%s.sched_cyc", name), sched_cyc, exp_sched);
    check_val($sformatf("%s.tiles_done", name), int'(bus.tiles_done), exp_tiles);
    check_val($sformatf("%s.err_timeout", name), int'(bus.err_timeout), int'(exp_tmo));
    check_val($sformatf("%s.err_op", name), int'(bus.err_op), int'(exp_eop));
    check_val($sformatf("%s.op_code", name), int'(bus.tp_op_code), op & 7);
    check_val($sformatf("%s.busy_ready", name), busy_bad, 0);
    check_val($sformatf("%s.op_during_tile", name), op_bad, 0);
    $display("cmd %s op=%0d rows=%0d cols=%0d starts=%0d tiles_done=%0d err_to=%0d err_op=%0d sched_cyc=%0d",
             name, op, rows, cols, obs_n, bus.tiles_done, bus.err_timeout, bus.err_op, sched_cyc);
  endtask

  initial begin
    int starts, rise_at, sd_seen;

    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_rows  = 3'd0;
    bus.cmd_cols  = 3'd0;
    bus.tp_done   = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // 2x3 grid, completion 5 cycles after each start
    for (int k = 0; k < 64; k++) dly[k] = 5;
    run_cmd(0, 1, 2, 1'b0, "basic");

    run_cmd(6, 2, 3, 1'b0, "illegal_op");

    for (int k = 0; k < 64; k++) dly[k] = 100;
    run_cmd(4, 0, 0, 1'b0, "timeout");

    dly[0] = 3;
    run_cmd(0, 0, 1, 1'b1, "done_held");

    dly[0] = T; dly[1] = 2;
    run_cmd(2, 0, 1, 1'b0, "edge_at_expiry");

    dly[0] = T + 1; dly[1] = 2;
    run_cmd(3, 0, 1, 1'b0, "edge_after_expiry");

    for (int k = 0; k < 64; k++) dly[k] = $urandom_range(1, 2);
    run_cmd(1, 7, 7, 1'b0, "full_grid");

    // Reset during the wait of the third tile of a 2x2 command
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd3; bus.cmd_rows = 3'd1; bus.cmd_cols = 3'd1;
    bus.tp_done = 1'b0;
    starts = 0; rise_at = 1 << 30;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (bus.tp_start) begin
        starts++;
        rise_at = n + 3;
      end
      bus.tp_done = (n == rise_at);
      if (starts == 3 && n == rise_at - 2) break;
    end
    bus.tp_done = 1'b0;
    check_val("midrst.starts_before", starts, 3);
    #1 rst = 1'b1;
    #1 check_reset_vals("midrst");
    sd_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.sched_done) sd_seen++;
    end
    check_val("midrst.no_sched_done", sd_seen, 0);
    rst = 1'b0;
    dly[0] = 4;
    run_cmd(1, 0, 0, 1'b0, "post_reset");

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 64; k++)
        dly[k] = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 1, T + 2) : $urandom_range(1, 8);
      run_cmd($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7), 1'b0,
              $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
